// File: rtl/maxnet_pkg.sv
// Shared definitions for the MaxNet operand store: controller states and
// the IEEE-754 constants used as default lateral-inhibition weights.
package maxnet_pkg;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        FILL   = 2'd1,
        FULL   = 2'd2,
        STREAM = 2'd3
    } state_e;

    localparam logic [31:0] FP_ONE     = 32'h3f800000;
    localparam logic [31:0] FP_NEG_0P2 = 32'hbe4ccccd;

endpackage

// File: rtl/maxnet_weight_row.sv
// Combinational generator for one row of the lateral-inhibition matrix:
// element j is DIAG on the diagonal and OFFDIAG everywhere else.
module maxnet_weight_row
    import maxnet_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter int               N       = 4,
    parameter logic [WIDTH-1:0] DIAG    = FP_ONE,
    parameter logic [WIDTH-1:0] OFFDIAG = FP_NEG_0P2,
    localparam int              RW      = $clog2(N)
) (
    input  logic [RW-1:0]      row_i,
    output logic [N*WIDTH-1:0] w_o
);

    always_comb begin
        w_o = '0;
        for (int j = 0; j < N; j++) begin
            w_o[j*WIDTH +: WIDTH] = (RW'(j) == row_i) ? DIAG : OFFDIAG;
        end
    end

endmodule

// File: rtl/maxnet_vector_mem.sv
// MaxNet operand store: serial X-vector load, write-back and row streaming of
// the generated weight matrix. MAXNET_MEM_DOUBLE_BUFFER_EN adds a shadow load bank.
module maxnet_vector_mem
    import maxnet_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter int               N       = 4,
    parameter logic [WIDTH-1:0] DIAG    = FP_ONE,
    parameter logic [WIDTH-1:0] OFFDIAG = FP_NEG_0P2,
    localparam int              RW      = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush_i,
    input  logic               load_valid_i,
    output logic               load_ready_o,
    input  logic [WIDTH-1:0]   load_data_i,
    input  logic               start_i,
    output logic               rd_valid_o,
    input  logic               rd_ready_i,
    output logic [RW-1:0]      rd_row_o,
    output logic [N*WIDTH-1:0] rd_w_o,
    output logic [N*WIDTH-1:0] rd_x_o,
    input  logic               wb_valid_i,
    input  logic [N*WIDTH-1:0] wb_data_i,
    output logic               full_o,
    output logic               done_o
);

    state_e               state_q, state_d;
    logic [N*WIDTH-1:0]   x_q, x_d;
    logic [RW-1:0]        cnt_q, cnt_d;
    logic [RW-1:0]        row_q, row_d;
    logic                 done_q, done_d;
    logic                 load_fire, rd_fire, last_word, last_row, copy;

`ifdef MAXNET_MEM_DOUBLE_BUFFER_EN
    logic [N*WIDTH-1:0]   sh_q, sh_d;
    logic                 sh_full_q, sh_full_d;

    // Shadow bank is promoted only while no pass is reading X.
    assign copy         = sh_full_q && (state_q == EMPTY || state_q == FULL);
    assign load_ready_o = !sh_full_q;
`else
    assign copy         = 1'b0;
    assign load_ready_o = (state_q == EMPTY) || (state_q == FILL);
`endif

    assign load_fire  = load_valid_i && load_ready_o;
    assign rd_valid_o = (state_q == STREAM);
    assign rd_fire    = rd_valid_o && rd_ready_i;
    assign last_word  = (cnt_q == RW'(N-1));
    assign last_row   = (row_q == RW'(N-1));
    assign full_o     = (state_q == FULL) || (state_q == STREAM);
    assign done_o     = done_q;
    assign rd_row_o   = row_q;
    assign rd_x_o     = x_q;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        done_d  = 1'b0;
`ifdef MAXNET_MEM_DOUBLE_BUFFER_EN
        sh_d      = sh_q;
        sh_full_d = sh_full_q;
`endif
        if (flush_i) begin
            state_d = EMPTY;
            x_d     = '0;
            cnt_d   = '0;
            row_d   = '0;
`ifdef MAXNET_MEM_DOUBLE_BUFFER_EN
            sh_d      = '0;
            sh_full_d = 1'b0;
`endif
        end else begin
`ifdef MAXNET_MEM_DOUBLE_BUFFER_EN
            if (load_fire) begin
                sh_d[cnt_q*WIDTH +: WIDTH] = load_data_i;
                cnt_d     = last_word ? '0 : cnt_q + RW'(1);
                sh_full_d = last_word;
            end
            if (copy) begin
                x_d       = sh_q;
                sh_full_d = 1'b0;
                state_d   = FULL;
            end else if (state_q == FULL && wb_valid_i) begin
                x_d = wb_data_i;
            end
`else
            if (load_fire) begin
                x_d[cnt_q*WIDTH +: WIDTH] = load_data_i;
                cnt_d   = last_word ? '0 : cnt_q + RW'(1);
                state_d = last_word ? FULL : FILL;
            end
            if (state_q == FULL && wb_valid_i) begin
                x_d = wb_data_i;
            end
`endif
            if (state_q == FULL && start_i && !copy) begin
                state_d = STREAM;
                row_d   = '0;
            end
            if (rd_fire) begin
                if (last_row) begin
                    state_d = FULL;
                    row_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            x_q     <= '0;
            cnt_q   <= '0;
            row_q   <= '0;
            done_q  <= 1'b0;
`ifdef MAXNET_MEM_DOUBLE_BUFFER_EN
            sh_q      <= '0;
            sh_full_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            done_q  <= done_d;
`ifdef MAXNET_MEM_DOUBLE_BUFFER_EN
            sh_q      <= sh_d;
            sh_full_q <= sh_full_d;
`endif
        end
    end

    maxnet_weight_row #(
        .WIDTH   (WIDTH),
        .N       (N),
        .DIAG    (DIAG),
        .OFFDIAG (OFFDIAG)
    ) u_weight_row (
        .row_i (row_q),
        .w_o   (rd_w_o)
    );

endmodule

// File: doc/maxnet_vector_mem.md
# maxnet_vector_mem

Parametrised operand store for the MaxNet datapath. It holds one N-element IEEE-754 single-precision activation vector (X bank) and a generated N×N lateral-inhibition weight matrix, with diagonal DIAG and all other entries OFFDIAG. On `start` it streams the matrix row by row to the PE array over a valid/ready handshake. Updated activations are written back between iterations, and new input vectors are loaded serially. It replaces the fixed 4-input, file-initialised store.

## Interface
- `WIDTH`, 32, word width in bits
- `N`, 4, vector length and matrix dimension (≥2)
- `DIAG`, 32'h3f800000, weight value where row == column (1.0)
- `OFFDIAG`, 32'hbe4ccccd, weight value where row != column (−0.2)
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `flush`  in  1  synchronous clear of the X bank state and the load counter
- `load_valid` / `load_ready`  in / out  1 / 1  serial input-word handshake
- `load_data`  in  WIDTH  input word; element index = arrival order
- `start`  in  1  begin streaming one matrix pass
- `rd_valid` / `rd_ready`  out / in  1 / 1  row handshake towards the PE array
- `rd_row`  out  $clog2(N)  index of the row being presented
- `rd_w`  out  N*WIDTH  weight row `rd_row`; element j sits at bits [j*WIDTH +: WIDTH]
- `rd_x`  out  N*WIDTH  full X bank, same packing
- `wb_valid`  in  1  write back a full vector
- `wb_data`  in  N*WIDTH  activation vector to write back
- `full`  out  1  X bank holds a complete vector
- `done`  out  1  one-cycle pulse after the last row is accepted

## Operation
- States:
  - EMPTY: no valid X.
  - FILL: partial load in progress.
  - FULL: vector valid, idle.
  - STREAM: rows being presented.
- Reset values: state EMPTY, X bank all 0, load count 0, row 0, `load_ready`=1, `rd_valid`=0, `full`=0, `done`=0.
- Load:
  - Each `load_valid && load_ready` writes `load_data` to X[cnt] and increments cnt.
  - EMPTY→FILL on the first word; the N-th word moves to FULL and wraps cnt to 0.
  - `load_ready`=1 only in EMPTY/FILL.
- FULL + `start` → STREAM, with row=0. `start` in any other state is ignored.
- STREAM:
  - `rd_valid`=1; `rd_w` is row `rd_row` of the generated matrix; `rd_x` is the X bank.
  - On `rd_valid && rd_ready`, the row increments.
  - Acceptance of row N−1 → FULL, row=0, `done`=1 for the next cycle.
  - `rd_ready` low stalls indefinitely; outputs stay stable.
- Write-back: `wb_valid` in FULL overwrites all N elements of X. `wb_valid` in any other state is dropped.
- `flush`:
  - Forces EMPTY and cnt=0, and clears X.
  - Takes priority over load, start, write-back and streaming, including mid-stream; `rd_valid` drops the next cycle and no `done` is raised.
- Async reset mid-stream returns immediately to reset values.

## Timing
- `start` sampled at edge k → `rd_valid`=1 from cycle k+1.
- With `rd_ready` held 1, a full pass takes N cycles. `done` is asserted in cycle k+N+1 and `start` is accepted again in that same cycle.
- Load: N accepted words; `full`=1 the cycle after the N-th word.
- Write-back visible on `rd_x` the cycle after `wb_valid`.
- All outputs are driven from registers or from register-to-constant muxes only; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `MAXNET_MEM_DOUBLE_BUFFER_EN`.
- Without the macro: single X bank, behaviour as above.
- With the macro:
  - Loads always write a shadow bank. `load_ready`=1 whenever the shadow bank is not full, in every state including STREAM.
  - When the shadow bank is full and the state is EMPTY or FULL, the shadow bank is copied to X in one cycle, it is emptied, and the state becomes FULL.
  - A copy coinciding with `wb_valid` wins and the write-back is dropped.
  - Load-to-`full` latency rises by 1 cycle.
  - `flush` also clears the shadow bank.

## Structure
- Shared package `maxnet_pkg`:
  - state enum (EMPTY, FILL, FULL, STREAM)
  - FP constants `FP_ONE` = 32'h3f800000 and `FP_NEG_0P2` = 32'hbe4ccccd, used as defaults for DIAG/OFFDIAG
- One sub-module, `maxnet_weight_row`: combinational generator that, given a row index, outputs the N-word row. Element j = DIAG if j == row, else OFFDIAG.

## Test plan
- Reset then load 3f800000, 3f000000, 3e800000, 3e000000 (N=4) → `full`=1 one cycle after the 4th word, and `rd_x` equals those words in order.
- `start`, `rd_ready`=1 → rows 0..3 on 4 consecutive cycles.
  - Row 1 `rd_w` = {be4ccccd, 3f800000, be4ccccd, be4ccccd}, element 0 first.
  - `done` pulses exactly once, in cycle 5.
- `rd_ready` toggled 1/0 every cycle → each row is held stable while stalled, the pass takes 8 cycles, and no row is skipped or repeated.
- `wb_valid` in FULL with all elements 3f000000 → `rd_x` updates the next cycle. The same `wb_valid` pulse during STREAM leaves X unchanged.
- `flush` asserted during row 2 → `rd_valid`=0 next cycle, `full`=0, no `done`, `load_ready`=1.
- With `MAXNET_MEM_DOUBLE_BUFFER_EN`: load a second vector during STREAM → `load_ready` stays 1, the active X is unchanged until `done`, and the new X is visible the cycle after the return to FULL.
